// File: rtl/shuttle_pkg.sv
// Shared types and constants for the shuttlecock motion controller.
// Positions are 12-bit signed internally; velocities are 8-bit signed.
package shuttle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HELD1,
    S_HELD2,
    S_FLIGHT,
    S_LANDED
  } shuttle_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic signed [7:0]  vel_t;
  typedef logic signed [11:0] pos_t;

  localparam pos_t X_MAX = pos_t'(SCREEN_W - 1);

  // Keep an x coordinate inside the visible screen.
  function automatic pos_t clamp_x(input pos_t v);
    if (v[11])     return '0;
    if (v > X_MAX) return X_MAX;
    return v;
  endfunction

  // Saturate an internal coordinate onto the 10-bit unsigned output range.
  function automatic logic [9:0] sat10(input pos_t v);
    if (v[11])              return '0;
    if (v > pos_t'(1023))   return '1;
    return v[9:0];
  endfunction

endpackage

// File: rtl/shuttle_motion_tick.sv
// Brings the ~60 Hz frame strobe into the Clk domain and turns its rising
// edge into a single-cycle tick, three Clk edges after the strobe rises.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1, sync2, sync2_d;

  // NOTE: reset sits in the sensitivity list so the flops clear without a running clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync1   <= frame_clk;
      sync2   <= sync1;
      sync2_d <= sync2;
      tick    <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/shuttle_motion.sv
// Shuttlecock motion and rally controller: serves, flight ballistics, hits,
// wall bounces and landings, all advanced once per frame tick.
module shuttle_motion
  import shuttle_pkg::*;
#(
  parameter int FLOOR_Y     = 400,
  parameter int NET_X       = 320,
  parameter int SERVE_Y     = 340,
  parameter int HAND_OFF    = 16,
  parameter int HIT_RANGE   = 24,
  parameter int HIT_Y_MIN   = 280,
  parameter int SERVE_VX    = 4,
  parameter int SERVE_VY    = -12,
  parameter int HIT_VX      = 5,
  parameter int HIT_VY      = -10,
  parameter int GRAVITY     = 1,
  parameter int LAND_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       ball_exist1,
  input  logic       ball_shoot1,
  input  logic       ball_hit1,
  input  logic       ball_exist2,
  input  logic       ball_shoot2,
  input  logic       ball_hit2,
  input  logic [9:0] figure1_x,
  input  logic [9:0] figure2_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_on,
  output logic       point_valid,
  output logic       point_to
);

  localparam pos_t FLOOR_P  = pos_t'(FLOOR_Y);
  localparam pos_t NET_P    = pos_t'(NET_X);
  localparam pos_t SERVE_P  = pos_t'(SERVE_Y);
  localparam pos_t HAND_P   = pos_t'(HAND_OFF);
  localparam pos_t RANGE_P  = pos_t'(HIT_RANGE);
  localparam pos_t HIT_Y_P  = pos_t'(HIT_Y_MIN);
  localparam vel_t SERVE_VX_P = vel_t'(SERVE_VX);
  localparam vel_t SERVE_VY_P = vel_t'(SERVE_VY);
  localparam vel_t HIT_VX_P   = vel_t'(HIT_VX);
  localparam vel_t HIT_VY_P   = vel_t'(HIT_VY);
  localparam vel_t GRAVITY_P  = vel_t'(GRAVITY);
  localparam logic [7:0] LAND_LAST = 8'(LAND_FRAMES - 1);

  logic tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  shuttle_state_t state, state_n;
  pos_t       pos_x, pos_y, pos_x_n, pos_y_n;
  vel_t       vx, vy, vx_n, vy_n;
  logic [7:0] land_cnt, land_cnt_n;
  logic       point_valid_n, point_to_n;

  pos_t       hand1, hand2;
  logic       side2, hit_sel, toward;
  logic [9:0] fig_sel;
  pos_t       dx, adx, nx, ny;
  vel_t       hvx, hvy;

  assign hand1 = clamp_x(pos_t'({2'b00, figure1_x}) + HAND_P);
  assign hand2 = clamp_x(pos_t'({2'b00, figure2_x}) - HAND_P);

  assign ball_x  = sat10(pos_x);
  assign ball_y  = sat10(pos_y);
  assign ball_on = (state != S_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      pos_x       <= '0;
      pos_y       <= '0;
      vx          <= '0;
      vy          <= '0;
      land_cnt    <= '0;
      point_valid <= 1'b0;
      point_to    <= 1'b0;
    end else begin
      state       <= state_n;
      pos_x       <= pos_x_n;
      pos_y       <= pos_y_n;
      vx          <= vx_n;
      vy          <= vy_n;
      land_cnt    <= land_cnt_n;
      point_valid <= point_valid_n;
      point_to    <= point_to_n;
    end
  end

  // NOTE: every signal written here gets a value before any branch, so no latch can form.
  always_comb begin
    // Hit resolution: only the player on the ball's current side may connect.
    side2   = (pos_x >= NET_P);
    fig_sel = side2 ? figure2_x : figure1_x;
    hit_sel = side2 ? ball_hit2 : ball_hit1;
    toward  = side2 ? (!vx[7] && (vx != '0)) : vx[7];
    dx      = pos_x - pos_t'({2'b00, fig_sel});
    adx     = dx[11] ? -dx : dx;
    hvx     = vx;
    hvy     = vy;
    if (hit_sel && (adx <= RANGE_P) && (pos_y >= HIT_Y_P) && toward) begin
      hvx = side2 ? -HIT_VX_P : HIT_VX_P;
      hvy = HIT_VY_P;
    end
    nx = pos_x + pos_t'(hvx);
    ny = pos_y + pos_t'(hvy);

    state_n       = state;
    pos_x_n       = pos_x;
    pos_y_n       = pos_y;
    vx_n          = vx;
    vy_n          = vy;
    land_cnt_n    = land_cnt;
    point_valid_n = 1'b0;
    point_to_n    = point_to;

    if (tick) begin
      case (state)
        S_IDLE: begin
          if (ball_exist1) begin
            state_n = S_HELD1;
            pos_x_n = hand1;
            pos_y_n = SERVE_P;
          end else if (ball_exist2) begin
            state_n = S_HELD2;
            pos_x_n = hand2;
            pos_y_n = SERVE_P;
          end
        end
        S_HELD1: begin
          pos_x_n = hand1;
          pos_y_n = SERVE_P;
          if (ball_shoot1) begin
            state_n = S_FLIGHT;
            vx_n    = SERVE_VX_P;
            vy_n    = SERVE_VY_P;
          end else if (!ball_exist1) begin
            state_n = S_IDLE;
          end
        end
        S_HELD2: begin
          pos_x_n = hand2;
          pos_y_n = SERVE_P;
          if (ball_shoot2) begin
            state_n = S_FLIGHT;
            vx_n    = -SERVE_VX_P;
            vy_n    = SERVE_VY_P;
          end else if (!ball_exist2) begin
            state_n = S_IDLE;
          end
        end
        S_FLIGHT: begin
          vx_n = hvx;
          vy_n = hvy + GRAVITY_P;
          if (nx[11]) begin
            pos_x_n = '0;
            vx_n    = -hvx;
          end else if (nx > X_MAX) begin
            pos_x_n = X_MAX;
            vx_n    = -hvx;
          end else begin
            pos_x_n = nx;
          end
          pos_y_n = ny;
          // The point goes to the player on the far side of where it lands.
          if (ny >= FLOOR_P) begin
            pos_y_n       = FLOOR_P;
            vx_n          = '0;
            vy_n          = '0;
            state_n       = S_LANDED;
            land_cnt_n    = '0;
            point_valid_n = 1'b1;
            point_to_n    = (pos_x_n < NET_P);
          end
        end
        S_LANDED: begin
          if (land_cnt == LAND_LAST) begin
            state_n    = S_IDLE;
            land_cnt_n = '0;
          end else begin
            land_cnt_n = land_cnt + 8'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shuttle_motion.sv
// Randomised scoreboard bench for shuttle_motion: a frame-level rally model
// predicts the sprite position and point pulse after every frame tick.
module tb_shuttle_motion;

  localparam int M_IDLE = 0, M_HELD1 = 1, M_HELD2 = 2, M_FLIGHT = 3, M_LANDED = 4;

  typedef struct {
    int x;
    int y;
    bit on;
    bit pv;
    bit pt;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       ball_exist1 = 0, ball_shoot1 = 0, ball_hit1 = 0;
  logic       ball_exist2 = 0, ball_shoot2 = 0, ball_hit2 = 0;
  logic [9:0] figure1_x = '0, figure2_x = '0;
  logic [9:0] ball_x, ball_y;
  logic       ball_on, point_valid, point_to;

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];

  int m_state = M_IDLE;
  int m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_rest = 0;
  bit m_pt = 0;

  shuttle_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .ball_exist1 (ball_exist1),
    .ball_shoot1 (ball_shoot1),
    .ball_hit1   (ball_hit1),
    .ball_exist2 (ball_exist2),
    .ball_shoot2 (ball_shoot2),
    .ball_hit2   (ball_hit2),
    .figure1_x   (figure1_x),
    .figure2_x   (figure2_x),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_on     (ball_on),
    .point_valid (point_valid),
    .point_to    (point_to)
  );

  always #10 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_rest = 0; m_pt = 0;
  endtask

  // One frame of rally rules, applied to the inputs currently driven.
  task automatic model_step();
    exp_t e;
    bit   landed = 0;
    case (m_state)
      M_IDLE: begin
        if (ball_exist1) begin
          m_state = M_HELD1; m_x = int'(figure1_x) + 16; m_y = 340;
        end else if (ball_exist2) begin
          m_state = M_HELD2; m_x = int'(figure2_x) - 16; m_y = 340;
        end
      end
      M_HELD1: begin
        m_x = int'(figure1_x) + 16; m_y = 340;
        if (ball_shoot1) begin m_state = M_FLIGHT; m_vx = 4; m_vy = -12; end
        else if (!ball_exist1) m_state = M_IDLE;
      end
      M_HELD2: begin
        m_x = int'(figure2_x) - 16; m_y = 340;
        if (ball_shoot2) begin m_state = M_FLIGHT; m_vx = -4; m_vy = -12; end
        else if (!ball_exist2) m_state = M_IDLE;
      end
      M_FLIGHT: begin
        bit left;
        left = (m_x < 320);
        if (left && ball_hit1 && iabs(m_x - int'(figure1_x)) <= 24 && m_y >= 280 && m_vx < 0) begin
          m_vx = 5; m_vy = -10;
        end else if (!left && ball_hit2 && iabs(m_x - int'(figure2_x)) <= 24 && m_y >= 280 && m_vx > 0) begin
          m_vx = -5; m_vy = -10;
        end
        m_x = m_x + m_vx;
        m_y = m_y + m_vy;
        m_vy = m_vy + 1;
        if (m_x < 0)   begin m_x = 0;   m_vx = -m_vx; end
        if (m_x > 639) begin m_x = 639; m_vx = -m_vx; end
        if (m_y >= 400) begin
          m_y = 400; m_vx = 0; m_vy = 0;
          m_state = M_LANDED; m_rest = 30;
          m_pt = (m_x < 320);
          landed = 1;
        end
      end
      default: begin
        m_rest = m_rest - 1;
        if (m_rest == 0) m_state = M_IDLE;
      end
    endcase
    e.x  = m_x;
    e.y  = (m_y < 0) ? 0 : m_y;
    e.on = (m_state != M_IDLE);
    e.pv = landed;
    e.pt = m_pt;
    exp_q.push_back(e);
  endtask

  // Issue one frame strobe; the expected result is queued before the tick.
  task automatic frame();
    @(negedge Clk);
    model_step();
    frame_clk = 1'b1;
    repeat (8) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic clear_flags();
    ball_exist1 = 0; ball_shoot1 = 0; ball_hit1 = 0;
    ball_exist2 = 0; ball_shoot2 = 0; ball_hit2 = 0;
  endtask

  task automatic run_to_idle(input string name);
    int n = 0;
    clear_flags();
    while (m_state != M_IDLE && n < 150) begin
      frame();
      n++;
    end
    check({name, "_reached_idle"}, int'(m_state == M_IDLE), 1);
  endtask

  // Monitor: outputs settle on the fourth Clk edge after the strobe rises.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      repeat (4) @(posedge Clk);
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_underflow: got an output update, expected none queued");
      end else begin
        e = exp_q.pop_front();
        check("ball_x", int'(ball_x), e.x);
        check("ball_y", int'(ball_y), e.y);
        check("ball_on", int'(ball_on), int'(e.on));
        check("point_valid", int'(point_valid), int'(e.pv));
        if (e.pv) check("point_to", int'(point_to), int'(e.pt));
      end
      @(negedge Clk);
      check("point_valid_width", int'(point_valid), 0);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_ball_x", int'(ball_x), 0);
    check("rst_ball_y", int'(ball_y), 0);
    check("rst_ball_on", int'(ball_on), 0);
    check("rst_point_valid", int'(point_valid), 0);
    check("rst_point_to", int'(point_to), 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Player 1 serve from x=100, then a full flight to landing and rest.
    figure1_x = 10'd100; figure2_x = 10'd500;
    ball_exist1 = 1; frame();
    check("held1_x", int'(ball_x), 116);
    check("held1_y", int'(ball_y), 340);
    ball_shoot1 = 1; frame();
    ball_shoot1 = 0; frame();
    check("serve_t1_x", int'(ball_x), 120);
    check("serve_t1_y", int'(ball_y), 328);
    frame();
    check("serve_t2_y", int'(ball_y), 317);
    run_to_idle("serve1");
    check("idle_ball_on", int'(ball_on), 0);

    // Player 2 serves from the left half; player 1 returns it at once.
    figure2_x = 10'd300; ball_exist2 = 1; frame();
    check("held2_x", int'(ball_x), 284);
    ball_shoot2 = 1; frame();
    clear_flags(); ball_hit1 = 1; figure1_x = 10'd284; frame();
    check("hit_x", int'(ball_x), 289);
    check("hit_y", int'(ball_y), 330);
    ball_hit1 = 0; frame();
    check("after_hit_x", int'(ball_x), 294);
    check("after_hit_y", int'(ball_y), 321);
    run_to_idle("rally");

    // Serve into the right wall.
    figure1_x = 10'd621; ball_exist1 = 1; frame();
    check("wall_held_x", int'(ball_x), 637);
    ball_shoot1 = 1; frame();
    clear_flags(); frame();
    check("wall_clamp_x", int'(ball_x), 639);
    frame();
    check("wall_bounce_x", int'(ball_x), 635);
    // Wrong-side swing by player 1 while the ball is on the right.
    ball_hit1 = 1; figure1_x = 10'd620; frame();
    check("wrong_side_x", int'(ball_x), 631);

    // Asynchronous reset between ticks, mid-flight.
    clear_flags();
    frame();
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrst_ball_x", int'(ball_x), 0);
    check("midrst_ball_y", int'(ball_y), 0);
    check("midrst_ball_on", int'(ball_on), 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    figure2_x = 10'd400; ball_exist2 = 1; frame();
    check("post_rst_held2_on", int'(ball_on), 1);
    check("post_rst_held2_x", int'(ball_x), 384);

    // Randomised play, with figures steered near the ball during flight.
    for (int i = 0; i < 450; i++) begin
      clear_flags();
      figure1_x = 10'($urandom_range(623));
      figure2_x = 10'($urandom_range(639, 16));
      case (m_state)
        M_IDLE: begin
          ball_exist1 = ($urandom_range(3) == 1) || ($urandom_range(4) == 0);
          ball_exist2 = ($urandom_range(2) == 0);
        end
        M_HELD1: begin
          ball_exist1 = ($urandom_range(9) != 0);
          ball_shoot1 = ($urandom_range(2) == 0);
          ball_shoot2 = $urandom_range(1);
        end
        M_HELD2: begin
          ball_exist2 = ($urandom_range(9) != 0);
          ball_shoot2 = ($urandom_range(2) == 0);
          ball_shoot1 = $urandom_range(1);
        end
        M_FLIGHT: begin
          if (m_x < 320) figure1_x = 10'(lim(m_x + int'($urandom_range(60)) - 30, 0, 623));
          else           figure2_x = 10'(lim(m_x + int'($urandom_range(60)) - 30, 16, 639));
          ball_hit1 = $urandom_range(1);
          ball_hit2 = $urandom_range(1);
        end
        default: begin
          ball_exist1 = $urandom_range(1);
          ball_hit2   = $urandom_range(1);
        end
      endcase
      frame();
    end

    repeat (20) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shuttle_motion.md
# shuttle_motion

Shuttlecock motion and rally controller. Sits directly downstream of the two stick-figure FSMs and consumes their `ball_exist`, `ball_shoot` and `ball_hit` flags together with each figure's x position. Once per video frame it advances the shuttle position under simple integer ballistics and resolves hits, side-wall bounces and landings. It drives the shuttle sprite position to the renderer and a one-cycle point pulse to the scoreboard.

## Interface
Parameters:
- `FLOOR_Y`, 400: landing line, in pixels.
- `NET_X`, 320: court split; player 1 is on the left, player 2 on the right.
- `SERVE_Y`, 340: y at which the held or served shuttle sits.
- `HAND_OFF`, 16: x offset of the hand from the figure centre.
- `HIT_RANGE`, 24: maximum |ball_x − figure_x| for a hit to connect.
- `HIT_Y_MIN`, 280: ball_y must be ≥ this for a hit to connect.
- `SERVE_VX`, 4 and `SERVE_VY`, −12: launch velocity magnitudes for a serve.
- `HIT_VX`, 5 and `HIT_VY`, −10: launch velocity magnitudes for a hit.
- `GRAVITY`, 1: added to vy every frame.
- `LAND_FRAMES`, 30: number of frames the shuttle rests on the floor before returning to IDLE.

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset` in 1: asynchronous, active-high.
- `frame_clk` in 1: ~60 Hz frame strobe; sampled in the `Clk` domain.
- `ball_exist1`, `ball_shoot1`, `ball_hit1` in 1 each: player 1 flags.
- `ball_exist2`, `ball_shoot2`, `ball_hit2` in 1 each: player 2 flags.
- `figure1_x`, `figure2_x` in 10 each: figure centre x positions.
- `ball_x`, `ball_y` out 10 each: shuttle position.
- `ball_on` out 1: shuttle is visible.
- `point_valid` out 1: one-`Clk` pulse when a rally ends.
- `point_to` out 1: 0 = point to player 1, 1 = point to player 2; valid while `point_valid` is high.

## Operation
- Frame tick: `frame_clk` passes through a two-flop synchronizer and a rising-edge detector, producing a one-`Clk` `tick`. All state and position updates occur only on `tick`.
- States: IDLE, HELD1, HELD2, FLIGHT, LANDED.
- IDLE:
  - `ball_on`=0.
  - On `ball_exist1` & !`ball_exist2` → HELD1.
  - On `ball_exist2` & !`ball_exist1` → HELD2.
  - If both are set, player 1 wins and the next state is HELD1.
- HELD1 / HELD2:
  - `ball_on`=1, `ball_y`=SERVE_Y.
  - `ball_x` tracks the server's hand: `figure1_x`+HAND_OFF in HELD1, `figure2_x`−HAND_OFF in HELD2.
  - On the server's `ball_shoot` → FLIGHT, with vx=+SERVE_VX (player 1) or −SERVE_VX (player 2) and vy=SERVE_VY.
  - If the server's `ball_exist` drops without a shoot → IDLE.
- FLIGHT, evaluated once per tick:
  1. Hit check. Only the player on the ball's current side is eligible: player 1 if `ball_x` < NET_X, otherwise player 2. The hit connects when that player's `ball_hit` is 1, |`ball_x`−`figure_x`| ≤ HIT_RANGE, `ball_y` ≥ HIT_Y_MIN, and vx points toward that player. On a hit, vx=±HIT_VX (away from the hitter) and vy=HIT_VY.
  2. Position update: x+=vx, y+=vy, then vy+=GRAVITY.
  3. Walls: a new x < 0 clamps to 0; a new x > 639 clamps to 639. In either case vx is negated.
  4. Floor: a new y ≥ FLOOR_Y clamps y to FLOOR_Y, sets vx=vy=0 and moves to LANDED. `point_to` = 1 if `ball_x` < NET_X, else 0. `point_valid` pulses for exactly one `Clk`.
- LANDED:
  - `ball_on`=1 and the position is frozen.
  - A frame counter counts LAND_FRAMES ticks, then → IDLE.
- Arithmetic:
  - Velocities are signed 8-bit.
  - Position math is done in 12-bit signed, then clamped and truncated to 10-bit unsigned.
  - A negative y is allowed internally; output `ball_y` saturates to 0.
- Reset, including mid-flight: IDLE, `ball_x`=0, `ball_y`=0, `ball_on`=0, `point_valid`=0, `point_to`=0, vx=vy=0, counter=0.

## Timing
- `tick` asserts 3 `Clk` cycles after the rising edge of `frame_clk`.
- Outputs update on the `Clk` edge following `tick` and hold until the next tick.
- Input flags are sampled on `tick` only. A flag must be stable across the tick cycle; the figure FSMs guarantee this by holding their flags for whole frames.
- `point_valid` is high for exactly one `Clk` cycle per landing, coincident with the FLIGHT→LANDED update.
- If a hit and a landing occur on the same tick, the hit wins: the new velocity is applied before the floor check.

## Structure
- `shuttle_pkg`:
  - state enum `shuttle_state_t`.
  - screen constants `SCREEN_W`=640 and `SCREEN_H`=480.
  - signed velocity type `vel_t` (8-bit).
- Sub-module `frame_tick_gen`: two-flop synchronizer plus rising-edge detector, `Clk`/`Reset` → `tick`.

## Test plan
- Serve, player 1: `figure1_x`=100, `ball_exist1`=1 → (116,340) held; `ball_shoot1` → after tick 1 (120,328), vy=−11.
- Hit return: ball moving left at (130,300), `figure2`… player 1 at x=120 with `ball_hit1`=1 → vx=+5, vy=−10; next tick (135,290).
- Landing: ball at (200,395) with vy=+6 → y=400, state LANDED, one-cycle `point_valid` with `point_to`=1; after 30 ticks → IDLE, `ball_on`=0.
- Wall bounce: ball at (637,200) with vx=+4 → x=639, vx=−4.
- Wrong-side hit: ball at x=400 with `ball_hit1`=1 → no velocity change.
- Async reset asserted mid-flight between ticks → outputs go to 0 immediately; a subsequent `ball_exist2` reaches HELD2.
